apb_timer: RTL and testbench
============================

// Module: apb_timer
// PURPOSE
//  APB3 slave timer on one slot of the APB sub-system, behind the AXI-to-APB bridge (pclk domain).
//  Prescaled 32-bit down-counter with reload, one-shot/periodic modes and a level interrupt.
//  timer_int is ORed into xx_intc_int next to uart0_int for the C906 interrupt controller.
// PARAMETERS
//  ADDR_W   32  paddr width; only paddr[4:2] decoded, paddr[1:0] ignored
//  CNT_W    32  counter/LOAD width (<=32; upper prdata bits read 0)
//  PRESC_W  8   prescaler field width in CTRL
// PORTS
//  pclk       in   1       APB clock
//  prst_n     in   1       async active-low reset; deassertion must be synchronised to pclk externally
//  psel       in   1       APB select
//  penable    in   1       APB access phase
//  pwrite     in   1       1=write
//  paddr      in   ADDR_W  byte address
//  pwdata     in   32      write data
//  prdata     out  32      read data, valid in access phase
//  pready     out  1       tied 1 (zero wait states)
//  pslverr    out  1       error on unmapped offset, access phase only
//  timer_int  out  1       level IRQ = STATUS.PEND & CTRL.IRQ_EN
//  pwm_out    out  1       only with APB_TIMER_PWM_EN
// BEHAVIOUR
//  Registers (byte offset): 0x00 CTRL RW: [0]EN [1]AUTO_RELOAD [2]IRQ_EN [8+:PRESC_W]PRESCALE
//   0x04 LOAD RW; 0x08 COUNT RO (writes ignored, no error); 0x0C STATUS [0]PEND, write-1-to-clear
//   0x10 PWM_CMP RW (macro only; without macro 0x10 is unmapped)
//  Write commits on psel&penable&pwrite (one cycle). prdata is combinational from registers; 0 on unmapped.
//  Reset: all registers 0, prescaler 0, prdata 0, pslverr 0, timer_int 0, pwm_out 0.
//  Prescaler: while EN, psc counts 0..PRESCALE; tick when psc==PRESCALE, psc->0. PRESCALE=0 => tick every cycle.
//   EN=0 holds psc at 0 and freezes COUNT.
//  Counter on tick: COUNT!=0 -> COUNT-1; COUNT==0 -> PEND<=1, then AUTO_RELOAD ? COUNT<=LOAD : EN<=0.
//   Period = (LOAD+1)*(PRESCALE+1) pclk cycles; LOAD=0 with auto-reload fires every tick.
//  Write to LOAD also sets COUNT<=pwdata and psc<=0 the same cycle; it has priority over a coincident tick.
//  CTRL write with EN 0->1 clears psc; first tick PRESCALE+1 cycles later.
//  STATUS W1C and expiry in the same cycle: set wins (PEND stays 1).
//  One-shot expiry clears EN in the same cycle PEND sets; a coincident CTRL write wins over that clear.
//  timer_int registered-free: combinational from PEND and IRQ_EN flops (no glitch source).
//  prst_n assertion mid-count: immediate return to reset values; no pending interrupt survives.
// CONFIGURATION
//  APB_TIMER_PWM_EN defined: PWM_CMP register at 0x10; pwm_out registered, =1 when EN & COUNT<PWM_CMP.
//   PWM_CMP > LOAD gives constant 1 while EN.
//  Undefined: no PWM_CMP flop, no pwm_out port, 0x10 returns pslverr.
// STRUCTURE
//  Package apb_timer_pkg: localparams for register offsets; CTRL bit indices;
//   packed struct ctrl_t {presc, irq_en, auto_reload, en}.
//  Sub-module timer_prescaler: en, presc, clr in; tick out.
//  Top holds APB decode, registers, counter and IRQ logic.
// TESTING
//  1 Reset: prst_n low mid-count -> all reads 0, timer_int=0, pready=1.
//  2 Periodic: LOAD=9, PRESCALE=3, CTRL=0x0307 -> PEND every 40 cycles; timer_int high until W1C 0x1 to 0x0C.
//  3 One-shot: LOAD=5, PRESCALE=0, CTRL=0x5 -> PEND after 6 cycles; CTRL.EN reads 0; COUNT stays 0.
//  4 Race: W1C STATUS same cycle as expiry -> PEND remains 1; LOAD write same cycle as tick -> COUNT=pwdata.
//  5 Errors: read 0x14 and write 0x1C -> pslverr=1 in access phase, prdata=0, no register change.
//  6 PWM (macro on): LOAD=9, PWM_CMP=3, PRESCALE=0 -> pwm_out high 3 of every 10 cycles.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register byte offsets, CTRL bit
// positions, the CTRL register layout and a helper that packs CTRL for reads.
package apb_timer_pkg;

    localparam int PRESC_W = 8;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_LOAD    = 5'h04;
    localparam logic [4:0] OFF_COUNT   = 5'h08;
    localparam logic [4:0] OFF_STATUS  = 5'h0C;
    localparam logic [4:0] OFF_PWM_CMP = 5'h10;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_PRESC_LSB       = 8;

    typedef struct packed {
        logic [PRESC_W-1:0] presc;
        logic               irq_en;
        logic               auto_reload;
        logic               en;
    } ctrl_t;

    // Places the CTRL fields at their bus bit positions; unused bits read 0.
    function automatic logic [31:0] packCtrl(input ctrl_t c);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN_BIT]                 = c.en;
        v[CTRL_AUTO_RELOAD_BIT]        = c.auto_reload;
        v[CTRL_IRQ_EN_BIT]             = c.irq_en;
        v[CTRL_PRESC_LSB +: PRESC_W]   = c.presc;
        return v;
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: counts 0..i_presc while enabled and emits a
// one-cycle tick when the count reaches i_presc. Disabling or i_clr restarts
// the count from zero.
module timer_prescaler #(
    parameter int W = 8
) (
    input  logic         i_pclk,
    input  logic         i_prst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_presc,
    input  logic         i_clr,
    output logic         o_tick
);

    logic [W-1:0] r_psc;

    assign o_tick = i_en & (r_psc == i_presc);

    // The count returns to zero whenever the timer is off, a reload restarts
    // the period, or a tick has just been issued; otherwise it advances.
    always_ff @(posedge i_pclk or negedge i_prst_n) begin
        if (!i_prst_n) begin
            r_psc <= '0;
        end else if (!i_en || i_clr || o_tick) begin
            r_psc <= '0;
        end else begin
            r_psc <= r_psc + 1'b1;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB3 timer slave: prescaled down-counter with reload, one-shot or periodic
// operation and a level interrupt. Zero wait states; unmapped offsets raise
// pslverr. Optional PWM output and PWM_CMP register are built when the macro
// APB_TIMER_PWM_EN is defined.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              timer_int
`ifdef APB_TIMER_PWM_EN
    ,
    output logic              pwm_out
`endif
);

    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_count;
    logic             r_pend;

    logic [4:0]       w_off;
    logic             w_access;
    logic             w_wr;
    logic             w_mapped;
    logic             w_wrCtrl;
    logic             w_wrLoad;
    logic             w_wrStatus;
    logic             w_tick;
    logic             w_expire;
    logic             w_unused;

    assign w_off      = {paddr[4:2], 2'b00};
    assign w_access   = psel & penable;
    assign w_wr       = w_access & pwrite;
    assign w_wrCtrl   = w_wr & (w_off == OFF_CTRL);
    assign w_wrLoad   = w_wr & (w_off == OFF_LOAD);
    assign w_wrStatus = w_wr & (w_off == OFF_STATUS);
    assign w_unused   = ^{paddr[ADDR_W-1:5], paddr[1:0]};

    assign w_expire   = w_tick & ~w_wrLoad & (r_count == '0);

    assign pready     = 1'b1;
    assign pslverr    = w_access & ~w_mapped;
    assign timer_int  = r_pend & r_ctrl.irq_en;

    timer_prescaler #(
        .W (PRESC_W)
    ) u_prescaler (
        .i_pclk   (pclk),
        .i_prst_n (prst_n),
        .i_en     (r_ctrl.en),
        .i_presc  (r_ctrl.presc),
        .i_clr    (w_wrLoad),
        .o_tick   (w_tick)
    );

    // CTRL: a bus write takes precedence, so software re-enabling in the
    // same cycle as a one-shot expiry keeps the timer running.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_ctrl <= '0;
        end else if (w_wrCtrl) begin
            r_ctrl.en          <= pwdata[CTRL_EN_BIT];
            r_ctrl.auto_reload <= pwdata[CTRL_AUTO_RELOAD_BIT];
            r_ctrl.irq_en      <= pwdata[CTRL_IRQ_EN_BIT];
            r_ctrl.presc       <= pwdata[CTRL_PRESC_LSB +: PRESC_W];
        end else if (w_expire && !r_ctrl.auto_reload) begin
            r_ctrl.en <= 1'b0;
        end
    end

    // LOAD holds the reload value used by periodic mode.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_load <= '0;
        end else if (w_wrLoad) begin
            r_load <= pwdata[CNT_W-1:0];
        end
    end

    // COUNT: a LOAD write restarts it immediately and overrides any tick;
    // otherwise each tick decrements, reloading at zero in periodic mode and
    // parking at zero in one-shot mode.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_count <= '0;
        end else if (w_wrLoad) begin
            r_count <= pwdata[CNT_W-1:0];
        end else if (w_tick) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end else if (r_ctrl.auto_reload) begin
                r_count <= r_load;
            end
        end
    end

    // PEND: expiry sets it and beats a simultaneous write-1-to-clear so an
    // event is never lost.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_pend <= 1'b0;
        end else if (w_expire) begin
            r_pend <= 1'b1;
        end else if (w_wrStatus && pwdata[0]) begin
            r_pend <= 1'b0;
        end
    end

`ifdef APB_TIMER_PWM_EN
    logic [CNT_W-1:0] r_pwmCmp;
    logic             r_pwm;
    logic             w_wrPwm;

    assign w_wrPwm = w_wr & (w_off == OFF_PWM_CMP);
    assign pwm_out = r_pwm;

    // PWM_CMP register holds the compare threshold.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_pwmCmp <= '0;
        end else if (w_wrPwm) begin
            r_pwmCmp <= pwdata[CNT_W-1:0];
        end
    end

    // Registered PWM output: high while running and COUNT is below compare.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= r_ctrl.en & (r_count < r_pwmCmp);
        end
    end
`endif

    // Address decode: which offsets exist in this build.
    always_comb begin
        w_mapped = 1'b0;
        case (w_off)
            OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS: w_mapped = 1'b1;
`ifdef APB_TIMER_PWM_EN
            OFF_PWM_CMP: w_mapped = 1'b1;
`endif
            default: w_mapped = 1'b0;
        endcase
    end

    // Read data straight from the registers; unmapped offsets return zero.
    always_comb begin
        prdata = '0;
        case (w_off)
            OFF_CTRL:    prdata = packCtrl(r_ctrl);
            OFF_LOAD:    prdata[CNT_W-1:0] = r_load;
            OFF_COUNT:   prdata[CNT_W-1:0] = r_count;
            OFF_STATUS:  prdata[0] = r_pend;
`ifdef APB_TIMER_PWM_EN
            OFF_PWM_CMP: prdata[CNT_W-1:0] = r_pwmCmp;
`endif
            default:     prdata = '0;
        endcase
    end

endmodule

// File: tb/tb_apb_timer.sv
// Directed testbench for apb_timer. Expected values are queued on a
// scoreboard as stimulus is issued and popped when the DUT output is sampled.
// Builds with or without APB_TIMER_PWM_EN.
module tb_apb_timer;

    logic        pclk;
    logic        prst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        timer_int;
`ifdef APB_TIMER_PWM_EN
    logic        pwm_out;
`endif

    typedef struct {
        string       tag;
        logic [31:0] value;
    } sbEntry_t;

    sbEntry_t scoreboard[$];
    int       errors;
    int       checks;

    apb_timer #(
        .ADDR_W (32),
        .CNT_W  (32)
    ) dut (
        .pclk      (pclk),
        .prst_n    (prst_n),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .timer_int (timer_int)
`ifdef APB_TIMER_PWM_EN
        ,
        .pwm_out   (pwm_out)
`endif
    );

    // 10 ns clock.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Queue an expected value.
    task automatic pushExpect(input string tag, input logic [31:0] value);
        sbEntry_t e;
        e.tag   = tag;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the observed value.
    task automatic checkOutput(input logic [31:0] observed);
        sbEntry_t e;
        checks++;
        if (scoreboard.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=%h expected=<none>", observed);
        end else begin
            e = scoreboard.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    // One APB transfer: setup phase, then access phase sampled before the
    // committing edge; returns 1 ns after that edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data,
                                 output logic [31:0] rd, output logic err);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        rd  = prdata;
        err = pslverr;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr,
                          input logic [31:0] expData, input logic expErr);
        logic [31:0] rd;
        logic        err;
        pushExpect({tag, "_data"}, expData);
        pushExpect({tag, "_err"}, {31'b0, expErr});
        applyStimulus(1'b0, addr, 32'h0, rd, err);
        checkOutput(rd);
        checkOutput({31'b0, err});
    endtask

    task automatic doWrite(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic expErr);
        logic [31:0] rd;
        logic        err;
        pushExpect({tag, "_err"}, {31'b0, expErr});
        applyStimulus(1'b1, addr, data, rd, err);
        checkOutput({31'b0, err});
    endtask

    task automatic checkIrq(input string tag, input logic expected);
        pushExpect(tag, {31'b0, expected});
        checkOutput({31'b0, timer_int});
    endtask

    // Directed sequence.
    initial begin
        errors  = 0;
        checks  = 0;
        prst_n  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        repeat (3) @(negedge pclk);
        prst_n = 1'b1;

        $display("[TB] reset state");
        checkIrq("rst_irq", 1'b0);
        pushExpect("rst_pready", 32'h1);
        checkOutput({31'b0, pready});
        doRead("rst_ctrl",   32'h00, 32'h0, 1'b0);
        doRead("rst_load",   32'h04, 32'h0, 1'b0);
        doRead("rst_count",  32'h08, 32'h0, 1'b0);
        doRead("rst_status", 32'h0C, 32'h0, 1'b0);

        $display("[TB] periodic mode");
        doWrite("per_load", 32'h04, 32'd9, 1'b0);
        doWrite("per_ctrl", 32'h00, 32'h0307, 1'b0);
        repeat (39) @(posedge pclk);
        #1 checkIrq("per_irq_before", 1'b0);
        @(posedge pclk);
        #1 checkIrq("per_irq_expire", 1'b1);
        doWrite("per_w1c", 32'h0C, 32'h1, 1'b0);
        checkIrq("per_irq_cleared", 1'b0);
        repeat (37) @(posedge pclk);
        #1 checkIrq("per_irq_before2", 1'b0);
        @(posedge pclk);
        #1 checkIrq("per_irq_expire2", 1'b1);
        doRead("per_ctrl_rd", 32'h00, 32'h0307, 1'b0);
        doRead("per_status",  32'h0C, 32'h1, 1'b0);
        doRead("per_alias",   32'h07, 32'd9, 1'b0);

        $display("[TB] reset mid-count");
        @(negedge pclk);
        #2 prst_n = 1'b0;
        #1 checkIrq("mid_rst_irq", 1'b0);
        pushExpect("mid_rst_pready", 32'h1);
        checkOutput({31'b0, pready});
        repeat (2) @(negedge pclk);
        prst_n = 1'b1;
        doRead("mid_ctrl",   32'h00, 32'h0, 1'b0);
        doRead("mid_load",   32'h04, 32'h0, 1'b0);
        doRead("mid_count",  32'h08, 32'h0, 1'b0);
        doRead("mid_status", 32'h0C, 32'h0, 1'b0);

        $display("[TB] one-shot mode");
        doWrite("os_load", 32'h04, 32'd5, 1'b0);
        doWrite("os_ctrl", 32'h00, 32'h5, 1'b0);
        repeat (5) @(posedge pclk);
        #1 checkIrq("os_irq_before", 1'b0);
        @(posedge pclk);
        #1 checkIrq("os_irq_expire", 1'b1);
        doRead("os_ctrl_rd", 32'h00, 32'h4, 1'b0);
        repeat (4) @(posedge pclk);
        doRead("os_count",   32'h08, 32'h0, 1'b0);
        doWrite("os_w1c", 32'h0C, 32'h1, 1'b0);
        checkIrq("os_irq_cleared", 1'b0);

        $display("[TB] races");
        doWrite("race_load", 32'h04, 32'd3, 1'b0);
        doWrite("race_ctrl", 32'h00, 32'h7, 1'b0);
        repeat (2) @(posedge pclk);
        doWrite("race_w1c_expire", 32'h0C, 32'h1, 1'b0);
        checkIrq("race_set_wins", 1'b1);
        doWrite("race_w1c", 32'h0C, 32'h1, 1'b0);
        checkIrq("race_w1c_clears", 1'b0);
        @(posedge pclk);
        doWrite("race_load_tick", 32'h04, 32'd100, 1'b0);
        doRead("race_count", 32'h08, 32'd99, 1'b0);
        doWrite("race_w1c2", 32'h0C, 32'h1, 1'b0);
        doWrite("race_stop", 32'h00, 32'h0, 1'b0);

        $display("[TB] error responses");
        doWrite("err_load", 32'h04, 32'h55, 1'b0);
        doRead("err_rd14",   32'h14, 32'h0, 1'b1);
        doWrite("err_wr1c",  32'h1C, 32'hFFFF_FFFF, 1'b1);
        doRead("err_ctrl",   32'h00, 32'h0, 1'b0);
        doRead("err_load_rd", 32'h04, 32'h55, 1'b0);
        doWrite("err_count_wr", 32'h08, 32'h1234, 1'b0);
        doRead("err_count_rd", 32'h08, 32'h55, 1'b0);
        doRead("err_status", 32'h0C, 32'h0, 1'b0);

`ifdef APB_TIMER_PWM_EN
        begin
            int highs;
            $display("[TB] pwm");
            doWrite("pwm_load", 32'h04, 32'd9, 1'b0);
            doWrite("pwm_cmp",  32'h10, 32'd3, 1'b0);
            doRead("pwm_cmp_rd", 32'h10, 32'd3, 1'b0);
            doWrite("pwm_ctrl", 32'h00, 32'h3, 1'b0);
            repeat (20) @(posedge pclk);
            highs = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge pclk);
                #1;
                if (pwm_out) highs++;
            end
            pushExpect("pwm_high_count", 32'd30);
            checkOutput(32'(highs));
            doWrite("pwm_stop", 32'h00, 32'h0, 1'b0);
        end
`else
        doRead("err_rd10", 32'h10, 32'h0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
